// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel divider, h/v counters, registered syncs and blanked colour.
// Define VGA_SYNC_TESTPAT_EN to replace rgb_in with a built-in 8-bar colour pattern.
module vga_sync_gen #(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] rgb_in,
  output logic        pixel_tick,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        frame_start,
  output logic [11:0] rgb_out
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
  localparam logic [9:0] H_VEND = 10'(H_VIS);
  localparam logic [9:0] V_VEND = 10'(V_VIS);
  localparam logic [9:0] HS_BEG = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END = 10'(V_VIS + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [9:0]    h_q, h_d;
  logic [9:0]    v_q, v_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_on_q, video_on_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          wrap_q, wrap_d;
  logic          fs_q, fs_d;
  logic          vis;
  logic [11:0]   colour;

`ifdef VGA_SYNC_TESTPAT_EN
  localparam logic [9:0] BAR_LAST = 10'(H_VIS / 8 - 1);

  logic [9:0]  bar_px_q, bar_px_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic        unused_rgb;

  assign unused_rgb = ^rgb_in;

  // Bar position tracks h_cnt; restarts with each line
  always_comb begin
    bar_px_d  = bar_px_q;
    bar_idx_d = bar_idx_q;
    if (pixel_tick) begin
      if (h_q == H_LAST) begin
        bar_px_d  = '0;
        bar_idx_d = '0;
      end else if (bar_px_q == BAR_LAST) begin
        bar_px_d  = '0;
        bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
      end else begin
        bar_px_d = bar_px_q + 10'd1;
      end
    end
  end

  // Bar counter state
  always_ff @(posedge clk) begin
    if (reset) begin
      bar_px_q  <= '0;
      bar_idx_q <= '0;
    end else begin
      bar_px_q  <= bar_px_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  // Bar colour lookup
  always_comb begin
    colour = 12'h000;
    unique case (bar_idx_q)
      3'd0: colour = 12'hFFF;
      3'd1: colour = 12'hFF0;
      3'd2: colour = 12'h0FF;
      3'd3: colour = 12'h0F0;
      3'd4: colour = 12'hF0F;
      3'd5: colour = 12'hF00;
      3'd6: colour = 12'h00F;
      3'd7: colour = 12'h000;
    endcase
  end
`else
  // Pass-through colour source
  always_comb begin
    colour = rgb_in;
  end
`endif

  // Pixel strobe: last divider phase while running
  always_comb begin
    pixel_tick = !reset && enable && (div_q == DIV_LAST);
  end

  // Next state for counters and decoded outputs; everything holds when disabled
  always_comb begin
    div_d      = div_q;
    h_d        = h_q;
    v_d        = v_q;
    hsync_d    = hsync_q;
    vsync_d    = vsync_q;
    video_on_d = video_on_q;
    rgb_d      = rgb_q;
    wrap_d     = wrap_q;
    fs_d       = fs_q;
    vis        = (h_q < H_VEND) && (v_q < V_VEND);
    if (enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
      if (pixel_tick) begin
        h_d = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
        if (h_q == H_LAST) begin
          v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        end
      end
      hsync_d    = !((h_q >= HS_BEG) && (h_q < HS_END));
      vsync_d    = !((v_q >= VS_BEG) && (v_q < VS_END));
      video_on_d = vis;
      rgb_d      = vis ? colour : 12'h000;
      wrap_d     = pixel_tick && (h_q == H_LAST) && (v_q == V_LAST);
      fs_d       = wrap_q;
    end
  end

  // State registers; reset wins over enable
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= '0;
      h_q        <= '0;
      v_q        <= '0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b0;
      rgb_q      <= '0;
      wrap_q     <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      div_q      <= div_d;
      h_q        <= h_d;
      v_q        <= v_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
      rgb_q      <= rgb_d;
      wrap_q     <= wrap_d;
      fs_q       <= fs_d;
    end
  end

  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = fs_q;
  assign rgb_out     = rgb_q;

endmodule
